// File: rtl/mult_iter.sv
// mult_iter: iterative WIDTH x WIDTH multiplier retiring BPC multiplier bits per
// cycle. Operands are captured as magnitudes plus a product sign, accumulated
// into a 2*WIDTH-bit register over K = WIDTH/BPC cycles, then sign-corrected.
// LO mode returns the low half and the HI_* modes return the high half.
module mult_iter #(
    parameter int WIDTH = 64,
    parameter int BPC   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             busy
);

    localparam int K  = WIDTH / BPC;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int W2 = 2 * WIDTH;

    generate
        if (BPC < 1 || WIDTH % BPC != 0) begin : g_bad_bpc
            $error("mult_iter: WIDTH must be a positive multiple of BPC");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [W2-1:0]    mcand_sh;   // multiplicand magnitude, pre-shifted to current digit
    logic [WIDTH-1:0] mplier;     // remaining multiplier magnitude bits, LSB digit first
    logic [W2-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic             neg;
    logic             hi_sel;
    logic [WIDTH-1:0] y_reg;

    logic             accept;
    logic             last;
    logic             a_signed;
    logic             b_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [W2-1:0]    partial;
    logic [W2-1:0]    acc_sum;
    logic [W2-1:0]    prod_final;

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign last      = (state == BUSY) && (cnt == CW'(K - 1));
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_y     = y_reg;

    // Convert operands to magnitude form; the most negative value negates to
    // itself, which read as unsigned is exactly its magnitude 2^(WIDTH-1).
    always_comb begin
        a_signed = in_mode[1];
        b_signed = (in_mode == 2'b10);
        a_neg    = a_signed && in_a[WIDTH-1];
        b_neg    = b_signed && in_b[WIDTH-1];
        a_mag    = a_neg ? ('0 - in_a) : in_a;
        b_mag    = b_neg ? ('0 - in_b) : in_b;
    end

    // Partial product for the current BPC-bit digit, built from shifted adds.
    always_comb begin
        partial = '0;
        for (int unsigned j = 0; j < BPC; j++) begin
            if (mplier[j]) begin
                partial = partial + (mcand_sh << j);
            end
        end
        acc_sum    = acc + partial;
        prod_final = neg ? ('0 - acc_sum) : acc_sum;
    end

    // Next-state logic for the IDLE -> BUSY -> DONE -> IDLE handshake cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)    state_nxt = BUSY;
            BUSY: if (last)      state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: capture operands on accept, accumulate one digit per BUSY
    // cycle, and load the selected, sign-corrected half on the final digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_sh <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            hi_sel   <= 1'b0;
            y_reg    <= '0;
        end else begin
            if (accept) begin
                mcand_sh <= {{WIDTH{1'b0}}, a_mag};
                mplier   <= b_mag;
                acc      <= '0;
                cnt      <= '0;
                neg      <= a_neg ^ b_neg;
                hi_sel   <= (in_mode != 2'b00);
            end else if (state == BUSY) begin
                acc      <= acc_sum;
                mcand_sh <= mcand_sh << BPC;
                mplier   <= mplier >> BPC;
                cnt      <= cnt + CW'(1);
                if (last) begin
                    y_reg <= hi_sel ? prod_final[W2-1:WIDTH] : prod_final[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_iter.sv
// tb_mult_iter: directed and randomised checks for mult_iter at WIDTH=64, BPC=4.
module tb_mult_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic [1:0]  in_mode = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_y;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int n_acc    = 0;
    int n_out    = 0;

    mult_iter #(.WIDTH(64), .BPC(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y    (out_y),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Count input and output handshakes to confirm one result per accept.
    always @(posedge clk) begin
        if (in_valid && in_ready) n_acc++;
        if (out_valid && out_ready) n_out++;
    end

    // 128-bit reference product, half selected by mode.
    function automatic logic [63:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic [1:0] m);
        logic [127:0] ax, bx, p;
        ax = (m[1] && a[63]) ? {64'hFFFF_FFFF_FFFF_FFFF, a} : {64'h0, a};
        bx = (m == 2'b10 && b[63]) ? {64'hFFFF_FFFF_FFFF_FFFF, b} : {64'h0, b};
        p  = ax * bx;
        return (m == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    // Issue one operation from a negedge, measure latency from the accept
    // edge, hold out_ready low for 'stall' cycles, then complete the handshake.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] m,
                          input int stall, output logic [63:0] y, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        in_a      = a;
        in_b      = b;
        in_mode   = m;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
        in_mode  = 2'($urandom_range(0, 3));
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        y = out_y;
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (out_y !== 64'h0) begin failures++; $display("FAIL rst_out_y got=%h exp=0", out_y); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        in_a = 64'd3; in_b = 64'd5; in_mode = 2'b00; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_a = 64'hDEAD_BEEF_0123_4567;
        in_b = 64'h7654_3210_FEDC_BA98;
        in_mode = 2'b10;
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL basic_busy got busy=%b in_ready=%b exp busy=1 in_ready=0", busy, in_ready); end
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 16) begin failures++; $display("FAIL basic_latency got=%0d exp=16", lat); end
        checks++; if (out_y !== 64'd15) begin failures++; $display("FAIL basic_y got=%h exp=%h", out_y, 64'd15); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_return_idle got in_ready=%b out_valid=%b busy=%b exp 1 0 0", in_ready, out_valid, busy); end
    endtask

    task automatic test_modes();
        logic [63:0] va [7];
        logic [63:0] vb [7];
        logic [1:0]  vm [7];
        logic [63:0] ve [7];
        logic [63:0] y;
        int lat;
        va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'd2; vm[0] = 2'b01; ve[0] = 64'h1;
        va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'd2; vm[1] = 2'b10; ve[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        va[2] = 64'hFFFF_FFFF_FFFF_FFFF; vb[2] = 64'd2; vm[2] = 2'b11; ve[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        va[3] = 64'hFFFF_FFFF_FFFF_FFFF; vb[3] = 64'd2; vm[3] = 2'b00; ve[3] = 64'hFFFF_FFFF_FFFF_FFFE;
        va[4] = 64'h8000_0000_0000_0000; vb[4] = 64'h8000_0000_0000_0000; vm[4] = 2'b10; ve[4] = 64'h4000_0000_0000_0000;
        va[5] = 64'h8000_0000_0000_0000; vb[5] = 64'h8000_0000_0000_0000; vm[5] = 2'b01; ve[5] = 64'h4000_0000_0000_0000;
        va[6] = 64'h8000_0000_0000_0000; vb[6] = 64'h8000_0000_0000_0000; vm[6] = 2'b11; ve[6] = 64'hC000_0000_0000_0000;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], vm[i], 0, y, lat);
            checks++; if (y !== ve[i]) begin failures++; $display("FAIL modes_y[%0d] got=%h exp=%h", i, y, ve[i]); end
            checks++; if (lat !== 16) begin failures++; $display("FAIL modes_latency[%0d] got=%0d exp=16", i, lat); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        in_a = 64'd10; in_b = 64'd10; in_mode = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 16) begin failures++; $display("FAIL bp_latency got=%0d exp=16", lat); end
        checks++; if (out_y !== 64'd100) begin failures++; $display("FAIL bp_y got=%h exp=%h", out_y, 64'd100); end
        in_a = 64'd2; in_b = 64'd3; in_mode = 2'b00; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_y !== 64'd100 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d] got out_valid=%b out_y=%h in_ready=%b exp 1 %h 0", i, out_valid, out_y, in_ready, 64'd100);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_held_accept got busy=%b in_ready=%b exp 1 0", busy, in_ready); end
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 16) begin failures++; $display("FAIL bp_second_latency got=%0d exp=16", lat); end
        checks++; if (out_y !== 64'd6) begin failures++; $display("FAIL bp_second_y got=%h exp=%h", out_y, 64'd6); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [63:0] y;
        int lat;
        bit seen;
        in_a = 64'd123; in_b = 64'd456; in_mode = 2'b00; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_y !== 64'h0) begin failures++; $display("FAIL rstmid_out_y got=%h exp=0", out_y); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_stray_result got=%b exp=0", seen); end
        run_op(64'd7, 64'd6, 2'b00, 0, y, lat);
        checks++; if (y !== 64'd42) begin failures++; $display("FAIL rstmid_new_y got=%h exp=%h", y, 64'd42); end
        checks++; if (lat !== 16) begin failures++; $display("FAIL rstmid_new_latency got=%0d exp=16", lat); end
    endtask

    task automatic test_random();
        logic [63:0] a, b, y, e;
        logic [1:0]  m;
        int lat, stall, acc0, out0;
        acc0 = n_acc;
        out0 = n_out;
        for (int i = 0; i < 300; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 10 == 0) a = 64'h8000_0000_0000_0000;
            if (i % 15 == 0) b = 64'h8000_0000_0000_0000;
            if (i % 7 == 0)  a = 64'hFFFF_FFFF_FFFF_FFFF;
            m = 2'($urandom_range(0, 3));
            stall = $urandom_range(0, 3);
            e = ref_model(a, b, m);
            run_op(a, b, m, stall, y, lat);
            checks++; if (y !== e) begin failures++; $display("FAIL rand_y[%0d] a=%h b=%h mode=%0d got=%h exp=%h", i, a, b, m, y, e); end
            checks++; if (lat !== 16) begin failures++; $display("FAIL rand_latency[%0d] got=%0d exp=16", i, lat); end
        end
        checks++; if (n_acc - acc0 !== 300) begin failures++; $display("FAIL rand_accepts got=%0d exp=300", n_acc - acc0); end
        checks++; if (n_out - out0 !== 300) begin failures++; $display("FAIL rand_outputs got=%0d exp=300", n_out - out0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
